// File: rtl/move_decoder.sv
// move_decoder: recovers blank-tile slides from successive 8-puzzle boards.
// Optional GOAL_DETECT_EN macro adds the goal-board comparator on out_goal.
module move_decoder #(
    parameter int          CNT_W      = 8,
    parameter logic [35:0] GOAL_BOARD = 36'h123456780
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [35:0]      in_board,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_dir,
    output logic [3:0]       out_blank,
    output logic             out_err,
    output logic             out_goal,
    output logic [CNT_W-1:0] move_cnt
);

    typedef enum logic {EMPTY, TRACK} state_t;

    state_t      state_q, state_d;
    logic [35:0] prev_q;
    logic [3:0]  ob_q;
    logic        accept;
    logic [3:0]  nb;
    logic        found;
    logic [8:0]  diff;
    logic [3:0]  ndiff;
    logic        adj;
    logic [1:0]  dir;
    logic        legal;
    logic [4:0]  delta;

    function automatic logic [3:0] tile(input logic [35:0] b,
                                        input logic [3:0] p);
        tile = 4'd0;
        for (int i = 0; i < 9; i++)
            if (p == 4'(i)) tile = b[35-4*i -: 4];
    endfunction

    function automatic logic [1:0] row(input logic [3:0] p);
        row = (p < 4'd3) ? 2'd0 : (p < 4'd6) ? 2'd1 : 2'd2;
    endfunction

    assign in_ready = !start && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign delta    = {1'b0, nb} - {1'b0, ob_q};

    // Locate the lowest blank and the set of changed positions.
    always_comb begin
        nb    = 4'd0;
        found = 1'b0;
        diff  = '0;
        ndiff = 4'd0;
        for (int p = 8; p >= 0; p--) begin
            if (in_board[35-4*p -: 4] == 4'd0) begin
                nb    = 4'(p);
                found = 1'b1;
            end
        end
        for (int p = 0; p < 9; p++) begin
            diff[p] = in_board[35-4*p -: 4] != prev_q[35-4*p -: 4];
            ndiff   = ndiff + {3'b000, diff[p]};
        end
    end

    // Classify the blank displacement; sideways moves must stay in a row.
    always_comb begin
        adj = 1'b0;
        dir = 2'b00;
        unique case (delta)
            5'b11101: begin adj = 1'b1; dir = 2'b00; end
            5'b00011: begin adj = 1'b1; dir = 2'b01; end
            5'b11111: begin adj = row(nb) == row(ob_q); dir = 2'b10; end
            5'b00001: begin adj = row(nb) == row(ob_q); dir = 2'b11; end
            default:  begin adj = 1'b0; dir = 2'b00; end
        endcase
        legal = found && adj && (ndiff == 4'd2)
              && diff[ob_q] && diff[nb]
              && (tile(in_board, ob_q) == tile(prev_q, nb))
              && (tile(in_board, nb) == 4'd0);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // Next state: a found blank in EMPTY establishes the reference.
    always_comb begin
        state_d = state_q;
        if (start)
            state_d = EMPTY;
        else if (accept && state_q == EMPTY && found)
            state_d = TRACK;
    end

    // Reference board, counter and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= '0;
            ob_q      <= '0;
            move_cnt  <= '0;
            out_valid <= 1'b0;
            out_dir   <= 2'b00;
            out_blank <= 4'd0;
            out_err   <= 1'b0;
        end else if (start) begin
            prev_q    <= '0;
            ob_q      <= '0;
            move_cnt  <= '0;
            out_valid <= 1'b0;
            out_dir   <= 2'b00;
            out_blank <= 4'd0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_dir   <= 2'b00;
            out_blank <= 4'd0;
            if (state_q == EMPTY) begin
                out_valid <= !found;
                out_err   <= !found;
                if (found) begin
                    prev_q <= in_board;
                    ob_q   <= nb;
                end
            end else begin
                out_valid <= 1'b1;
                out_err   <= !legal;
                if (legal) begin
                    out_dir   <= dir;
                    out_blank <= nb;
                    prev_q    <= in_board;
                    ob_q      <= nb;
                    if (move_cnt != '1)
                        move_cnt <= move_cnt + 1'b1;
                end
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef GOAL_DETECT_EN
    logic goal_ok;
    assign goal_ok = (state_q == EMPTY) ? found : legal;

    // Goal flag travels with the result (and the reference board).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         out_goal <= 1'b0;
        else if (start)  out_goal <= 1'b0;
        else if (accept) out_goal <= goal_ok && (in_board == GOAL_BOARD);
    end
`else
    assign out_goal = 1'b0;
`endif

endmodule

// File: tb/tb_move_decoder.sv
// tb_move_decoder: directed self-checking bench for move_decoder.
// Checks decode, illegal moves, stalls, streaming, saturation, reset/start.
module tb_move_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [35:0] in_board = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_dir;
    logic [3:0]  out_blank;
    logic        out_err;
    logic        out_goal;
    logic [7:0]  move_cnt;

    int checks = 0;
    int errors = 0;

    move_decoder #(.CNT_W(8), .GOAL_BOARD(36'h123456780)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_board(in_board),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_dir(out_dir), .out_blank(out_blank), .out_err(out_err),
        .out_goal(out_goal), .move_cnt(move_cnt)
    );

    always #5 clk = ~clk;

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push(input logic [35:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_board = b;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL push_timeout in_ready got 0 exp 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_res(input string nm, input logic v,
                              input logic [1:0] d, input logic [3:0] bl,
                              input logic e, input logic [7:0] c);
        checks++;
        if ({out_valid, out_dir, out_blank, out_err, move_cnt}
            !== {v, d, bl, e, c}) begin
            errors++;
            $display("FAIL %s got v%0b d%0d b%0d e%0b c%0d exp v%0b d%0d b%0d e%0b c%0d",
                     nm, out_valid, out_dir, out_blank, out_err, move_cnt,
                     v, d, bl, e, c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({out_valid, out_dir, out_blank, out_err, out_goal, move_cnt}
            !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs got %0h exp 0",
                     {out_valid, out_dir, out_blank, out_err, out_goal, move_cnt});
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %0b exp 1", in_ready);
        end
    endtask

    task automatic test_legal();
        do_start();
        push(36'h123456780);
        expect_res("ref_no_output", 0, 2'd0, 4'd0, 0, 8'd0);
        push(36'h123456708);
        expect_res("left_7", 1, 2'b10, 4'd7, 0, 8'd1);
        push(36'h123406758);
        expect_res("up_4", 1, 2'b00, 4'd4, 0, 8'd2);
    endtask

    task automatic test_illegal();
        do_start();
        push(36'h120345678);
        push(36'h123045678);
        expect_res("row_wrap", 1, 2'd0, 4'd0, 1, 8'd0);
        push(36'h123045678);
        expect_res("wrap_again", 1, 2'd0, 4'd0, 1, 8'd0);
        push(36'h120345678);
        expect_res("identical", 1, 2'd0, 4'd0, 1, 8'd0);
        push(36'h102345678);
        expect_res("right_after_err", 1, 2'b10, 4'd1, 0, 8'd1);
        push(36'h012345687);
        expect_res("multi_tile", 1, 2'd0, 4'd0, 1, 8'd1);
        do_start();
        push(36'h123456781);
        expect_res("empty_no_blank", 1, 2'd0, 4'd0, 1, 8'd0);
    endtask

    task automatic test_stall();
        do_start();
        push(36'h123456780);
        push(36'h123456708);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_board = 36'h123406758;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_in_ready got %0b exp 0", in_ready);
            end
            expect_res("stall_hold", 1, 2'b10, 4'd7, 0, 8'd1);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready got %0b exp 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        expect_res("stall_release", 1, 2'b00, 4'd4, 0, 8'd2);
        @(posedge clk);
        #1;
        expect_res("valid_drop", 0, 2'b00, 4'd4, 0, 8'd2);
    endtask

    task automatic test_back_to_back();
        logic [35:0] bd [4];
        logic [1:0]  ed [4];
        logic [3:0]  eb [4];
        bd[0] = 36'h123456780; ed[0] = 2'b00; eb[0] = 4'd0;
        bd[1] = 36'h123456708; ed[1] = 2'b10; eb[1] = 4'd7;
        bd[2] = 36'h123406758; ed[2] = 2'b00; eb[2] = 4'd4;
        bd[3] = 36'h123046758; ed[3] = 2'b10; eb[3] = 4'd3;
        do_start();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_board = bd[i];
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_%0d got %0b exp 1", i, in_ready);
            end
            @(posedge clk);
            #1;
            if (i > 0)
                expect_res("b2b", 1, ed[i], eb[i], 0, 8'(i));
        end
        in_valid = 1'b0;
    endtask

    task automatic test_saturation();
        do_start();
        for (int i = 0; i <= 300; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_board = i[0] ? 36'h123456708 : 36'h123456780;
            @(posedge clk);
            #1;
            if (i == 255)
                expect_res("cnt_255", 1, 2'b10, 4'd7, 0, 8'd255);
        end
        in_valid = 1'b0;
        expect_res("cnt_saturated", 1, 2'b11, 4'd8, 0, 8'd255);
    endtask

    task automatic test_reset_start();
        push(36'h123456708);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_dir, out_blank, out_err, out_goal, move_cnt}
            !== 17'd0) begin
            errors++;
            $display("FAIL async_reset got %0h exp 0",
                     {out_valid, out_dir, out_blank, out_err, out_goal, move_cnt});
        end
        @(negedge clk);
        rst = 1'b0;
        push(36'h123456780);
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b1;
        in_board = 36'h123456780;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_in_ready got %0b exp 0", in_ready);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        in_valid = 1'b0;
        expect_res("start_clear", 0, 2'd0, 4'd0, 0, 8'd0);
        push(36'h123456708);
        expect_res("empty_after_start", 0, 2'd0, 4'd0, 0, 8'd0);
        push(36'h123456780);
        expect_res("right_8", 1, 2'b11, 4'd8, 0, 8'd1);
    endtask

    task automatic test_goal();
        logic exp_goal;
`ifdef GOAL_DETECT_EN
        exp_goal = 1'b1;
`else
        exp_goal = 1'b0;
`endif
        do_start();
        push(36'h123456708);
        push(36'h123456780);
        expect_res("goal_move", 1, 2'b11, 4'd8, 0, 8'd1);
        checks++;
        if (out_goal !== exp_goal) begin
            errors++;
            $display("FAIL goal_flag got %0b exp %0b", out_goal, exp_goal);
        end
        push(36'h123456708);
        checks++;
        if (out_goal !== 1'b0) begin
            errors++;
            $display("FAIL goal_clear got %0b exp 0", out_goal);
        end
    endtask

    initial begin
        test_reset();
        test_legal();
        test_illegal();
        test_stall();
        test_back_to_back();
        test_saturation();
        test_reset_start();
        test_goal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
